// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } rsp_t;

    // Misaligned, or above the implemented word range.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi_mask;
        hi_mask = ~((32'(1) << (addr_w + 2)) - 32'(1));
        return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous FIFO holding read responses; head is visible while not empty.
module rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Mem-stage data RAM responder: posted byte-enabled writes, in-order
// two-stage reads returned through a valid/ready response buffer.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned RAM_D = 2 ** ADDR_W;

    logic [WORD_W-1:0] r_ram [RAM_D];
    logic              r_req_ready;
    logic              r_s1_valid;
    logic              r_s1_bad;
    logic [ADDR_W-1:0] r_s1_idx;
    logic [CNT_W-1:0]  r_pending;
    logic [CNT_W-1:0]  w_pending_nxt;
    logic              w_accept;
    logic              w_bad;
    logic              w_rd_accept;
    logic              w_wr_accept;
    logic [ADDR_W-1:0] w_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    rsp_t              w_push_rsp;
    rsp_t              w_head;

    assign w_accept    = req_valid && r_req_ready;
    assign w_bad       = addr_bad(req_addr, ADDR_W);
    assign w_idx       = req_addr[ADDR_W+1:2];
    assign w_rd_accept = w_accept && !req_write;
    assign w_wr_accept = w_accept && req_write && !w_bad;

    // Byte-lane writes; a write seen during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    r_ram[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_pending_nxt = r_pending;
        case ({w_rd_accept, w_pop})
            2'b10:   w_pending_nxt = r_pending + CNT_W'(1);
            2'b01:   w_pending_nxt = r_pending - CNT_W'(1);
            default: w_pending_nxt = r_pending;
        endcase
    end

    // Stage 1 request latch and read credit tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_bad    <= 1'b0;
            r_s1_idx    <= '0;
            r_pending   <= '0;
            r_req_ready <= 1'b1;
        end else begin
            r_s1_valid  <= w_rd_accept;
            r_s1_bad    <= w_bad;
            r_s1_idx    <= w_idx;
            r_pending   <= w_pending_nxt;
            r_req_ready <= (w_pending_nxt < CNT_W'(RSP_DEPTH));
        end
    end

    // Stage 2: RAM read (skipped for bad addresses) feeding the buffer.
    always_comb begin
        w_push_rsp = '0;
        if (r_s1_bad) begin
            w_push_rsp.err = 1'b1;
        end else begin
            w_push_rsp.rdata = r_ram[r_s1_idx];
        end
    end

    assign w_push = r_s1_valid;
    assign w_pop  = !w_empty && rsp_ready;

    rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_rsp),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign req_ready = r_req_ready;
    assign rsp_valid = !w_empty;
    assign rsp_rdata = w_head.rdata;
    assign rsp_err   = w_head.err;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full && !w_pop))
        else $error("response buffer overflow");

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: reference RAM model, expected
// responses queued at request accept and compared on each response pop.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_pops = 0;
    rsp_t exp_q[$];
    logic [31:0] model [256];

    data_mem_responder #(.ADDR_W(8), .RSP_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    endfunction

    // Present one request, wait (bounded) for acceptance, update model/scoreboard.
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        int waited = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!req_ready) begin
            check("req_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (wr) begin
            if (!is_bad(addr)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end else if (is_bad(addr)) begin
            exp_q.push_back(rsp_t'{rdata: 32'd0, err: 1'b1});
        end else begin
            exp_q.push_back(rsp_t'{rdata: model[addr[9:2]], err: 1'b0});
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Response monitor: every pop must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                n_pops++;
            end
        end
    end

    initial begin
        int p0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        rst = 1'b0;

        // Full write then read, with response latency.
        rsp_ready = 1'b1;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        check("lat_early_valid", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_valid", 32'(rsp_valid), 32'd1);
        wait_drain();

        // Partial write, and write-then-read on consecutive cycles.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b1, 32'h10, 32'h000000AA, 4'h1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);
        do_req(1'b1, 32'h14, 32'h55AA0000, 4'hC);
        do_req(1'b0, 32'h14, 32'h0, 4'h0);
        wait_drain();

        // Back-pressure: two reads fill the credits, third waits.
        do_req(1'b1, 32'h0, 32'h11111111, 4'hF);
        do_req(1'b1, 32'h4, 32'h22222222, 4'hF);
        do_req(1'b1, 32'h8, 32'h33333333, 4'hF);
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        do_req(1'b0, 32'h4, 32'h0, 4'h0);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h8;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rdata", rsp_rdata, model[0]);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        do_req(1'b0, 32'h8, 32'h0, 4'h0);
        wait_drain();

        // Bad accesses.
        do_req(1'b0, 32'h13, 32'h0, 4'h0);
        do_req(1'b0, 32'h400, 32'h0, 4'h0);
        do_req(1'b1, 32'h400, 32'h12345678, 4'hF);
        do_req(1'b1, 32'h2, 32'h9ABCDEF0, 4'hF);
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        wait_drain();

        // Streaming reads with the consumer always ready.
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF);
        p0 = n_pops;
        for (int i = 0; i < 16; i++) do_req(1'b0, 32'(i * 4), 32'h0, 4'h0);
        wait_drain();
        check("stream_pops", 32'(n_pops - p0), 32'd16);

        // Reset with two reads outstanding.
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h0, 32'h0, 4'h0);
        do_req(1'b0, 32'h4, 32'h0, 4'h0);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        do_req(1'b0, 32'h4, 32'h0, 4'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0);
        wait_drain();

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
